// File: rtl/vme_bus_initiator_pkg.sv
// rtl/vme_bus_initiator_pkg.sv - shared types and constants for the VME bus initiator
package vme_initiator_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_RELEASE,
      ST_RESP
   } state_e;

   localparam int SYNC_DEPTH = 2;
   localparam int TMO_W      = 16;

endpackage

// File: rtl/vme_bus_initiator_if.sv
// rtl/vme_bus_initiator_if.sv - host request/response port plus VME strobe/data bus
interface vme_bus_initiator_if #(
   parameter int DW = 8
);
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          dsr;
   logic          dsw;
   logic          dtack;
   logic [DW-1:0] d_out;
   logic          d_oe;
   logic [DW-1:0] d_in;

   modport master (
      input  req_valid, req_write, req_wdata, rsp_ready, dtack, d_in,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, dsr, dsw, d_out, d_oe
   );

   modport slave (
      output req_valid, req_write, req_wdata, rsp_ready, dtack, d_in,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, dsr, dsw, d_out, d_oe
   );
endinterface

// File: rtl/vme_bus_initiator_sync2.sv
// rtl/vme_bus_initiator_sync2.sv - multi-flop synchronizer with synchronous active-low clear
module vme_sync2
   import vme_initiator_pkg::*;
(
   input  logic clk,
   input  logic resetn,
   input  logic d,
   output logic q
);
   logic [SYNC_DEPTH-1:0] sync_q;
   logic [SYNC_DEPTH-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[SYNC_DEPTH-2:0], d};
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[SYNC_DEPTH-1];
endmodule

// File: rtl/vme_bus_initiator.sv
// rtl/vme_bus_initiator.sv - four-phase dsr/dsw/dtack bus master, one cycle per host request
// Optional strobe timeout: VME_INITIATOR_TIMEOUT_EN
module vme_bus_initiator
   import vme_initiator_pkg::*;
#(
   parameter int DW        = 8,
   parameter int SETUP_CYC = 2
`ifdef VME_INITIATOR_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 64
`endif
) (
   input  logic                clk,
   input  logic                reset,
   vme_bus_initiator_if.master bus
);
   state_e        state_q, state_d;
   logic          write_q, write_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          err_q, err_d;
   logic [3:0]    setup_cnt_q, setup_cnt_d;
   logic          dtack_s;
   logic          req_ready;
`ifdef VME_INITIATOR_TIMEOUT_EN
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

   vme_sync2 u_dtack_sync (
      .clk    (clk),
      .resetn (reset),
      .d      (bus.dtack),
      .q      (dtack_s)
   );

   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      setup_cnt_d = setup_cnt_q;
      req_ready   = 1'b0;
`ifdef VME_INITIATOR_TIMEOUT_EN
      tmo_cnt_d   = tmo_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (bus.req_valid) begin
               write_d     = bus.req_write;
               wdata_d     = bus.req_wdata;
               rdata_d     = '0;
               err_d       = 1'b0;
               setup_cnt_d = '0;
               state_d     = ST_SETUP;
            end
         end
         ST_SETUP: begin
            // A responder still holding dtack from an earlier cycle keeps us here.
            if (setup_cnt_q != 4'(SETUP_CYC - 1)) begin
               setup_cnt_d = setup_cnt_q + 4'd1;
            end else if (!dtack_s) begin
`ifdef VME_INITIATOR_TIMEOUT_EN
               tmo_cnt_d = '0;
`endif
               state_d   = ST_STROBE;
            end
         end
         ST_STROBE: begin
`ifdef VME_INITIATOR_TIMEOUT_EN
            tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
            if (dtack_s) begin
               if (!write_q) rdata_d = bus.d_in;
               state_d = ST_RELEASE;
            end
`ifdef VME_INITIATOR_TIMEOUT_EN
            else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = ST_RELEASE;
            end
`endif
         end
         ST_RELEASE: begin
            if (!dtack_s) state_d = ST_RESP;
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               rdata_d = '0;
               err_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         write_q     <= 1'b0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         setup_cnt_q <= '0;
`ifdef VME_INITIATOR_TIMEOUT_EN
         tmo_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         setup_cnt_q <= setup_cnt_d;
`ifdef VME_INITIATOR_TIMEOUT_EN
         tmo_cnt_q   <= tmo_cnt_d;
`endif
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = (state_q == ST_RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign bus.dsr       = (state_q == ST_STROBE) && !write_q;
   assign bus.dsw       = (state_q == ST_STROBE) && write_q;
   assign bus.d_oe      = write_q && ((state_q == ST_SETUP) || (state_q == ST_STROBE));
   assign bus.d_out     = bus.d_oe ? wdata_q : '0;
endmodule

// File: tb/tb_vme_bus_initiator.sv
// tb/tb_vme_bus_initiator.sv - directed scoreboard bench with a behavioural dtack responder
module tb_vme_bus_initiator;
   typedef struct packed {
      logic [7:0] rdata;
      logic       err;
   } exp_t;

   logic clk;
   logic reset;
   vme_bus_initiator_if #(.DW(8)) bus ();

   vme_bus_initiator #(
      .DW(8),
      .SETUP_CYC(2)
`ifdef VME_INITIATOR_TIMEOUT_EN
      ,
      .TIMEOUT_CYC(8)
`endif
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   fail_cnt = 0;
   exp_t exp_q[$];

   logic       ack_en = 1'b1;
   int         ack_dly = 3;
   int         rel_dly = 2;
   logic [7:0] rd_val = 8'h00;
   logic [7:0] last_wdata = 8'h00;
   int         hi_cnt = 0;
   int         rel_cnt = 0;
   logic       m0 = 1'b0, m1 = 1'b0;
   logic       strobe_prev = 1'b0;
   int         oe_run = 0;
   logic       read_watch = 1'b0;
   logic       read_bad = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Responder: raises dtack some cycles after a strobe rises, drops it after the strobe falls.
   always @(posedge clk) begin
      #1;
      if (bus.dsr || bus.dsw) begin
         hi_cnt++;
         rel_cnt = 0;
         if (ack_en && hi_cnt >= ack_dly) bus.dtack = 1'b1;
      end else begin
         hi_cnt = 0;
         if (bus.dtack) begin
            rel_cnt++;
            if (rel_cnt >= rel_dly) begin
               bus.dtack = 1'b0;
               rel_cnt   = 0;
            end
         end
      end
      bus.d_in = bus.dtack ? rd_val : 8'hFF;
   end

   always @(posedge clk) begin
      if (!reset) begin
         m0 <= 1'b0;
         m1 <= 1'b0;
      end else begin
         m0 <= bus.dtack;
         m1 <= m0;
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         if ((bus.dsr || bus.dsw) && !strobe_prev) begin
            check("strobe_rise_dtack_s", {31'd0, m1}, 32'd0);
            check("strobe_exclusive", {31'd0, bus.dsr & bus.dsw}, 32'd0);
            if (bus.dsw) check("setup_oe_cycles", {31'd0, oe_run >= 2}, 32'd1);
         end
         if (bus.d_oe && !bus.dsw && bus.d_out === last_wdata) oe_run++;
         else if (!bus.dsw) oe_run = 0;
         if (read_watch && (bus.dsw || bus.d_oe)) read_bad = 1'b1;
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("rsp_rdata", {24'd0, bus.rsp_rdata}, {24'd0, e.rdata});
               check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
            end
         end
      end
      strobe_prev = bus.dsr || bus.dsw;
   end

   task automatic send(input logic wr, input logic [7:0] wd, input logic [7:0] rd_exp,
                       input logic err_exp);
      int n = 0;
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_wdata = wd;
      last_wdata    = wd;
      exp_q.push_back({rd_exp, err_exp});
      while (!bus.req_ready && n < 300) begin
         step();
         n++;
      end
      step();
      bus.req_valid = 1'b0;
      check("accept_bound", {31'd0, n < 300}, 32'd1);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!(bus.req_ready && exp_q.size() == 0) && n < 400) begin
         step();
         n++;
      end
      check(tag, {31'd0, n < 400}, 32'd1);
   endtask

   task automatic wait_rsp_valid(input string tag);
      int n = 0;
      while (!bus.rsp_valid && n < 300) begin
         step();
         n++;
      end
      check(tag, {31'd0, bus.rsp_valid}, 32'd1);
   endtask

   initial begin
      reset         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_wdata = 8'h00;
      bus.rsp_ready = 1'b0;
      bus.dtack     = 1'b0;
      bus.d_in      = 8'hFF;
      repeat (3) step();

      check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
      check("rst_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
      check("rst_dsr", {31'd0, bus.dsr}, 32'd0);
      check("rst_dsw", {31'd0, bus.dsw}, 32'd0);
      check("rst_d_oe", {31'd0, bus.d_oe}, 32'd0);
      check("rst_d_out", {24'd0, bus.d_out}, 32'd0);
      reset = 1'b1;
      step();

      // Write 0xA5
      bus.rsp_ready = 1'b1;
      send(1'b1, 8'hA5, 8'h00, 1'b0);
      wait_done("write_done");

      // Read 0x3C
      rd_val     = 8'h3C;
      read_watch = 1'b1;
      send(1'b0, 8'h00, 8'h3C, 1'b0);
      wait_done("read_done");
      read_watch = 1'b0;
      check("read_no_dsw_oe", {31'd0, read_bad}, 32'd0);

      // Back-to-back: read 0x11 then write 0x5C with req_valid held
      rd_val = 8'h11;
      send(1'b0, 8'h00, 8'h11, 1'b0);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_wdata = 8'h5C;
      last_wdata    = 8'h5C;
      exp_q.push_back({8'h00, 1'b0});
      wait_rsp_valid("b2b_first_rsp");
      step();
      check("b2b_idle_ready", {31'd0, bus.req_ready}, 32'd1);
      step();
      check("b2b_one_idle", {31'd0, bus.req_ready}, 32'd0);
      bus.req_valid = 1'b0;
      wait_done("b2b_done");

      // Reset while dsr is high and no dtack comes
      ack_en = 1'b0;
      send(1'b0, 8'h00, 8'h00, 1'b0);
      begin
         int n = 0;
         while (!bus.dsr && n < 50) begin
            step();
            n++;
         end
         check("mid_dsr_seen", {31'd0, bus.dsr}, 32'd1);
      end
      step();
      reset = 1'b0;
      step();
      check("mid_rst_dsr", {31'd0, bus.dsr}, 32'd0);
      check("mid_rst_ready", {31'd0, bus.req_ready}, 32'd1);
      exp_q.delete();
      step();
      reset  = 1'b1;
      ack_en = 1'b1;
      rd_val = 8'h5A;
      step();
      send(1'b0, 8'h00, 8'h5A, 1'b0);
      wait_done("post_rst_done");

`ifdef VME_INITIATOR_TIMEOUT_EN
      // Timeout: responder never acknowledges
      ack_en = 1'b0;
      send(1'b0, 8'h00, 8'h00, 1'b1);
      begin
         int n = 0;
         int hi = 0;
         while (!bus.dsr && n < 50) begin
            step();
            n++;
         end
         while (bus.dsr && hi < 100) begin
            step();
            hi++;
         end
         check("tmo_strobe_cycles", 32'(hi), 32'd8);
      end
      wait_done("tmo_done");
      ack_en = 1'b1;
`endif

      // Response held for 5 cycles
      bus.rsp_ready = 1'b0;
      rd_val        = 8'h77;
      send(1'b0, 8'h00, 8'h77, 1'b0);
      wait_rsp_valid("hold_rsp");
      for (int i = 0; i < 5; i++) begin
         step();
         check("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
         check("hold_rdata", {24'd0, bus.rsp_rdata}, 32'h77);
         check("hold_no_ready", {31'd0, bus.req_ready}, 32'd0);
      end
      bus.rsp_ready = 1'b1;
      wait_done("hold_done");
      check("cleared_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("cleared_rdata", {24'd0, bus.rsp_rdata}, 32'd0);

      step();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/vme_bus_initiator.md
Name: vme_bus_initiator

Overview:
- Clocked bus-master end of the VME-style dsr/dsw/dtack four-phase handshake. Our existing controller is the responder that answers dsr/dsw with dtack and drives lds/ldtack toward the device.
- Accepts single read/write requests from a host-side valid/ready port and runs one complete four-phase cycle per request on the bus strobes.
- Returns read data and completion status on a response port.
- Used as the bus stimulus generator and the system-side master in front of the controller.

Parameters:
- DW, 8, data bus width.
- SETUP_CYC, 2, cycles data/direction is stable before the strobe rises (1..15).
- TIMEOUT_CYC, 64, strobe-high cycles without dtack before abort (only with the timeout macro; 2..65535).

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  1  host request present.
- req_ready  output  1  initiator can accept a request (IDLE only).
- req_write  input  1  1 = write cycle (dsw), 0 = read cycle (dsr).
- req_wdata  input  DW  write data.
- rsp_valid  output  1  cycle complete, response held.
- rsp_ready  input  1  host consumes response.
- rsp_rdata  output  DW  captured read data (0 after a write).
- rsp_err  output  1  cycle aborted by timeout.
- dsr  output  1  read strobe to responder.
- dsw  output  1  write strobe to responder.
- dtack  input  1  responder acknowledge, asynchronous to clk.
- d_out  output  DW  bus data driven on writes.
- d_oe  output  1  bus data output enable.
- d_in  input  DW  bus data sampled on reads.

Behaviour:
- Reset: reset=0 at a rising edge forces IDLE on that edge. Outputs: req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, dsr=0, dsw=0, d_oe=0, d_out=0. Synchronizer flops and counters clear. Applies identically mid-cycle: strobes drop with no RELEASE phase.
- dtack passes through a 2-flop synchronizer (dtack_s). All FSM decisions use dtack_s only. The raw dtack is never used.
- States are IDLE, SETUP, STROBE, RELEASE, RESP.
- IDLE: req_ready=1. On req_valid: latch write/wdata, go to SETUP next edge, req_ready=0.
- SETUP: for writes, d_out=wdata and d_oe=1 from entry. Stay SETUP_CYC cycles, then go to STROBE.
- STROBE: dsw=1 (write) or dsr=1 (read). Hold until dtack_s=1.
  - Read: capture d_in into rsp_rdata on the same edge dtack_s is first seen high.
  - Then drop the strobe (and d_oe for writes) next edge and go to RELEASE.
- RELEASE: strobes 0. Wait dtack_s=0, then go to RESP. If dtack_s is already 0 on entry, transit in 1 cycle.
- RESP: rsp_valid=1 with data/err stable. On rsp_ready: go to IDLE next edge; rsp_valid, rsp_err and rsp_rdata are cleared there.
- dsr and dsw are never high together. A strobe never rises while dtack_s=1: an entry to STROBE with dtack_s=1 waits in SETUP.
- Minimum cycle latency, request accept to rsp_valid: 1 + SETUP_CYC + 1 + 2 (sync) + 1 + 2 (sync) + 1 cycles. With SETUP_CYC=2 and an instant responder this is 10 cycles.
- A dtack pulse seen outside STROBE/RELEASE is ignored; the FSM is unaffected.

Optional Feature:
- Macro: VME_INITIATOR_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs in STROBE. When it reaches TIMEOUT_CYC with dtack_s still 0: drop the strobe and d_oe, set rsp_err=1 and rsp_rdata=0, then go to RELEASE.
  - A dtack arriving on the same edge as expiry wins: normal completion, err=0.
- Undefined: no counter; STROBE waits indefinitely; rsp_err tied to 0.

Decomposition:
- Package vme_initiator_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, RELEASE, RESP);
  - the sync depth constant (2);
  - the timeout counter width (16).
- Sub-module vme_sync2: 2-flop synchronizer with synchronous active-low clear, reused for dtack.

Test Plan:
- Write 0xA5, SETUP_CYC=2, responder raises dtack 3 cycles after dsw↑ and drops it 2 cycles after dsw↓.
  - d_oe=1 and d_out=0xA5 at least 2 cycles before dsw↑.
  - rsp_valid=1 with rdata=0x00 and err=0.
- Read with d_in=0x3C held while dtack is high.
  - rsp_rdata=0x3C; dsw stays 0 throughout; d_oe never 1.
- Back-to-back requests, rsp_ready held 1.
  - The second strobe never rises before dtack_s has returned 0.
  - req_ready=1 for exactly one IDLE cycle between requests.
- reset=0 asserted while dsr=1 and waiting.
  - dsr=0 and req_ready=1 one edge later; a later request completes normally.
- With VME_INITIATOR_TIMEOUT_EN and TIMEOUT_CYC=8, the responder never acks.
  - dsr drops after 8 STROBE cycles; rsp_err=1; rsp_rdata=0.
- rsp_ready held 0 for 5 cycles in RESP.
  - rsp_valid and data stay stable; no new req_ready until consumed.
